// File: rtl/muldiv_seq_unit_if.sv
// rtl/muldiv_seq_unit_if.sv - request/response handshake bundle for the M-extension unit
interface muldiv_seq_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [XLEN-1:0]  req_rs1;
  logic [XLEN-1:0]  req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/muldiv_seq_unit.sv
// rtl/muldiv_seq_unit.sv - multi-cycle RV M-extension unit: latency-parametrised multiply, radix-2 restoring divide
module muldiv_seq_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  muldiv_seq_unit_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  typedef enum logic [1:0] {P_PREP, P_ITER, P_FIX} phase_e;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [2:0]       f3_q, f3_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic              signed_div, a_neg, b_neg, div_zero, div_ovf, ge;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic [XLEN:0]     shifted, sub;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    // rs1 is signed except for MULHU; rs2 is signed only for MULH
    mul_a      = (f3_q[1:0] == 2'b11) ? {{XLEN{1'b0}}, a_q} : {{XLEN{a_q[XLEN-1]}}, a_q};
    mul_b      = (f3_q[1:0] == 2'b01) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
    product    = mul_a * mul_b;
    signed_div = ~f3_q[0];
    a_neg      = signed_div & a_q[XLEN-1];
    b_neg      = signed_div & b_q[XLEN-1];
    div_zero   = (b_q == '0);
    div_ovf    = signed_div && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    shifted    = {rem_q, quo_q[XLEN-1]};
    sub        = shifted - {1'b0, b_q};
    ge         = ~sub[XLEN];
    quo_fix    = neg_quo_q ? -quo_q : quo_q;
    rem_fix    = neg_rem_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    f3_d      = f3_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    res_d     = res_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !flush) begin
          f3_d    = bus.req_funct3;
          a_d     = bus.req_rs1;
          b_d     = bus.req_rs2;
          tag_d   = bus.req_tag;
          cnt_d   = CNT_W'(MUL_LAT - 1);
          phase_d = P_PREP;
          state_d = bus.req_funct3[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          res_d   = (f3_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        case (phase_q)
          P_PREP: begin
            if (div_zero) begin
              res_d   = f3_q[1] ? a_q : '1;
              state_d = S_DONE;
            end else if (div_ovf) begin
              res_d   = f3_q[1] ? '0 : a_q;
              state_d = S_DONE;
            end else begin
              quo_d     = a_neg ? -a_q : a_q;
              rem_d     = '0;
              b_d       = b_neg ? -b_q : b_q;
              neg_quo_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              cnt_d     = CNT_W'(XLEN - 1);
              phase_d   = P_ITER;
            end
          end
          P_ITER: begin
            rem_d = ge ? sub[XLEN-1:0] : shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ge};
            if (cnt_q == '0) phase_d = P_FIX;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end
          default: begin
            res_d   = f3_q[1] ? rem_fix : quo_fix;
            state_d = S_DONE;
          end
        endcase
      end
      default: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= P_PREP;
      f3_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      f3_q      <= f3_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      res_q     <= res_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_data  = res_q;
  assign bus.resp_tag   = tag_q;
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb/tb_muldiv_seq_unit.sv - scoreboard bench for muldiv_seq_unit against an arithmetic reference model
module tb_muldiv_seq_unit;
  localparam int XLEN    = 32;
  localparam int TAG_W   = 5;
  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  always #5 clk = ~clk;

  muldiv_seq_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  muldiv_seq_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          q;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data %h tag %0d, expected no response", bus.resp_data, bus.resp_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_data", bus.resp_data, mon_e.data);
        check("resp_tag", 32'(bus.resp_tag), 32'(mon_e.tag));
      end
    end
  end

  task automatic scramble();
    bus.req_funct3 = 3'($urandom);
    bus.req_rs1    = $urandom;
    bus.req_rs2    = $urandom;
    bus.req_tag    = 5'($urandom);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold);
    int          lat, exp_lat, k;
    logic [31:0] exp_d;
    exp_d = ref_model(f3, a, b);
    exp_q.push_back('{data: exp_d, tag: tag});
    if (!f3[2]) exp_lat = MUL_LAT;
    else if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) exp_lat = 1;
    else exp_lat = XLEN + 2;
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_rs1    = a;
    bus.req_rs2    = b;
    bus.req_tag    = tag;
    bus.resp_ready = (hold == 0);
    @(negedge clk);
    k = 0;
    while (!bus.req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    scramble();
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (bus.resp_valid) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", 32'(bus.resp_valid), 32'd1);
        check("hold_data", bus.resp_data, exp_d);
        check("hold_tag", 32'(bus.resp_tag), 32'(tag));
        check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus.resp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    check("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_hs_resp_valid", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'b100;
    bus.req_rs1    = a;
    bus.req_rs2    = b;
    bus.req_tag    = tag;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    scramble();
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  d_f3  [14] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
  logic [31:0] d_a   [14] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd20, 32'd20,
                              32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000,
                              32'hDEAD_BEEF, 32'hDEAD_BEEF};
  logic [31:0] d_b   [14] = '{32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd3, 32'd3,
                              32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h0, 32'h0};
  int          d_hold[14] = '{0, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 5};

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_resp_tag", 32'(bus.resp_tag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 14; i++) run_op(d_f3[i], d_a[i], d_b[i], 5'(i + 7), d_hold[i]);

    // flush beats a same-cycle request
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'b000;
    flush          = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    @(negedge clk);
    check("flush_vs_accept_req_ready", 32'(bus.req_ready), 32'd1);
    check("flush_vs_accept_resp_valid", 32'(bus.resp_valid), 32'd0);

    start_div(32'd1000, 32'd7, 5'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_req_ready", 32'(bus.req_ready), 32'd1);
    check("flush_resp_valid", 32'(bus.resp_valid), 32'd0);
    run_op(3'd0, 32'd1234, 32'd5678, 5'd9, 0);

    start_div(32'd999, 32'd13, 5'd21);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("arst_resp_tag", 32'(bus.resp_tag), 32'd0);
    check("arst_resp_data", bus.resp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_req_ready", 32'(bus.req_ready), 32'd1);
    run_op(3'd1, 32'hFFFF_FF00, 32'd77, 5'd30, 0);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), 5'($urandom), $urandom_range(0, 2));

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
